lpc_periph: RTL and testbench

//  LPC target (peripheral) end of the LPC link: decodes host-issued I/O and memory read/write

---
 rtl/lpc_periph.sv | 221 ++++++++++++++++++++++
 tb/tb_lpc_periph.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_periph.sv
// -----------------------------------------------------------------------------
// lpc_periph -- LPC target end of the link.
//
// Decodes host-issued single-byte I/O and memory read/write cycles (16-bit
// address, 8-bit data) from LAD/LFRAME#. Each claimed cycle is handed to a
// simple req/ack register port. The block then returns SYNC, read data and
// the peripheral turnaround on LAD.
//
// Parameters
//   BASE_ADDR  decode base; a cycle is claimed when the address bits selected
//              by ADDR_MASK equal the same bits of BASE_ADDR
//   ADDR_MASK  decode mask; 0 claims every address
//   MAX_WAIT   long-wait SYNC nibbles sent before giving up with error SYNC
//
// Ports
//   clk_i           LPC clock; LAD/LFRAME# are sampled on the rising edge
//   rst_i           synchronous, active-high reset
//   lpc_lframe_n_i  LFRAME#, active low
//   lpc_lad_i       sampled LAD value
//   lpc_lad_o       LAD drive value
//   lpc_lad_oe_o    LAD output enable (the tristate is built above this block)
//   addr_o          decoded cycle address
//   wdata_o         write data, valid with req_o on writes
//   wr_o            1 = write, 0 = read
//   mem_o           1 = memory cycle, 0 = I/O cycle
//   req_o           transfer request, held until ack_i
//   ack_i           transfer accepted; only looked at while req_o = 1
//   rdata_i         read data, captured in the cycle ack_i = 1 on a read
//   state_o         FSM state, debug only
// -----------------------------------------------------------------------------
module lpc_periph #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_MASK = 16'h0000,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lpc_lframe_n_i,
  input  logic [3:0]  lpc_lad_i,
  output logic [3:0]  lpc_lad_o,
  output logic        lpc_lad_oe_o,
  output logic [15:0] addr_o,
  output logic [7:0]  wdata_o,
  output logic        wr_o,
  output logic        mem_o,
  output logic        req_o,
  input  logic        ack_i,
  input  logic [7:0]  rdata_i,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CYCTYPE = 4'd1,
    S_ADDR    = 4'd2,
    S_WDATA0  = 4'd3,
    S_WDATA1  = 4'd4,
    S_HTAR0   = 4'd5,
    S_HTAR1   = 4'd6,
    S_SYNC    = 4'd7,
    S_RDATA0  = 4'd8,
    S_RDATA1  = 4'd9,
    S_PTAR0   = 4'd10,
    S_PTAR1   = 4'd11
  } state_t;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [7:0]  wait_q;
  logic        ack_seen_q;
  logic [7:0]  rdata_q;
  logic [3:0]  lad_q;
  logic        oe_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        wr_q;
  logic        mem_q;
  logic        req_q;

  logic        ack_now;
  logic        ready;
  logic [15:0] addr_full;
  logic        hit;

  // An ack counts only while a request is outstanding.
  assign ack_now   = req_q & ack_i;
  // Ready if the ack arrives this cycle or arrived earlier for this request.
  assign ready     = ack_seen_q | ack_now;
  // Address including the nibble on LAD now (valid on the 4th ADDR nibble).
  assign addr_full = {addr_q[11:0], lpc_lad_i};
  assign hit       = (addr_full & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      wait_q     <= 8'd0;
      ack_seen_q <= 1'b0;
      rdata_q    <= 8'd0;
      lad_q      <= 4'hF;
      oe_q       <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 8'd0;
      wr_q       <= 1'b0;
      mem_q      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      // Handshake: note the ack, drop req next cycle, capture read data.
      if (ack_now) begin
        ack_seen_q <= 1'b1;
        req_q      <= 1'b0;
        if (!wr_q) rdata_q <= rdata_i;
      end

      if (!lpc_lframe_n_i) begin
        // START or abort from the host overrides whatever is in progress.
        oe_q       <= 1'b0;
        lad_q      <= 4'hF;
        req_q      <= 1'b0;
        ack_seen_q <= 1'b0;
        state_q    <= (lpc_lad_i == 4'b0000) ? S_CYCTYPE : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_CYCTYPE: begin
            // Accepted encodings are 0 m w 0 (m = memory, w = write).
            if (!lpc_lad_i[3] && !lpc_lad_i[0]) begin
              wr_q    <= lpc_lad_i[1];
              mem_q   <= lpc_lad_i[2];
              cnt_q   <= 2'd0;
              state_q <= S_ADDR;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_ADDR: begin
            addr_q <= addr_full;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (!hit) begin
                state_q <= S_IDLE;
              end else if (wr_q) begin
                state_q <= S_WDATA0;
              end else begin
                req_q      <= 1'b1;
                ack_seen_q <= 1'b0;
                wait_q     <= 8'd0;
                state_q    <= S_HTAR0;
              end
            end
          end
          S_WDATA0: begin
            wdata_q[3:0] <= lpc_lad_i;
            state_q      <= S_WDATA1;
          end
          S_WDATA1: begin
            wdata_q[7:4] <= lpc_lad_i;
            req_q        <= 1'b1;
            ack_seen_q   <= 1'b0;
            wait_q       <= 8'd0;
            state_q      <= S_HTAR0;
          end
          S_HTAR0: state_q <= S_HTAR1;
          S_HTAR1, S_SYNC: begin
            if (state_q == S_SYNC && lad_q == SYNC_READY) begin
              // Ready nibble was just sent: data phase or turnaround.
              lad_q   <= wr_q ? 4'hF : rdata_q[3:0];
              state_q <= wr_q ? S_PTAR0 : S_RDATA0;
            end else if (state_q == S_SYNC && lad_q == SYNC_ERR) begin
              lad_q   <= 4'hF;
              state_q <= S_PTAR0;
            end else begin
              // Choose the next SYNC nibble.
              oe_q    <= 1'b1;
              state_q <= S_SYNC;
              if (ready) begin
                lad_q <= SYNC_READY;
              end else if (wait_q == MAX_WAIT_C) begin
                lad_q <= SYNC_ERR;
                req_q <= 1'b0;
              end else begin
                lad_q  <= SYNC_LWAIT;
                wait_q <= wait_q + 8'd1;
              end
            end
          end
          S_RDATA0: begin
            lad_q   <= rdata_q[7:4];
            state_q <= S_RDATA1;
          end
          S_RDATA1: begin
            lad_q   <= 4'hF;
            state_q <= S_PTAR0;
          end
          S_PTAR0: begin
            oe_q    <= 1'b0;
            lad_q   <= 4'hF;
            state_q <= S_PTAR1;
          end
          S_PTAR1: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign lpc_lad_o    = lad_q;
  assign lpc_lad_oe_o = oe_q;
  assign addr_o       = addr_q;
  assign wdata_o      = wdata_q;
  assign wr_o         = wr_q;
  assign mem_o        = mem_q;
  assign req_o        = req_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_lpc_periph.sv
// -----------------------------------------------------------------------------
// tb_lpc_periph -- self-checking bench for lpc_periph.
//
// Acts as LPC host plus register-port responder. Each transaction's expected
// LAD response is built from the protocol rules: the ack delay d (cycles
// after req rises) gives max(0, d-1) long-wait nibbles, or an error SYNC once
// that exceeds MAX_WAIT.
// -----------------------------------------------------------------------------
module tb_lpc_periph;

  localparam logic [15:0] BASE = 16'h1000;
  localparam logic [15:0] MASK = 16'hF000;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lpc_lframe_n_i;
  logic [3:0]  lpc_lad_i;
  logic [3:0]  lpc_lad_o;
  logic        lpc_lad_oe_o;
  logic [15:0] addr_o;
  logic [7:0]  wdata_o;
  logic        wr_o;
  logic        mem_o;
  logic        req_o;
  logic        ack_i;
  logic [7:0]  rdata_i;
  logic [3:0]  state_o;

  int          checks    = 0;
  int          failures  = 0;
  int          ack_delay = 1000;
  int          req_cnt   = 0;
  int          txn_no    = 0;
  logic [7:0]  cur_rdata = 8'h00;

  always #5 clk = ~clk;

  lpc_periph #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .MAX_WAIT(MAXW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .lpc_lframe_n_i (lpc_lframe_n_i),
    .lpc_lad_i      (lpc_lad_i),
    .lpc_lad_o      (lpc_lad_o),
    .lpc_lad_oe_o   (lpc_lad_oe_o),
    .addr_o         (addr_o),
    .wdata_o        (wdata_o),
    .wr_o           (wr_o),
    .mem_o          (mem_o),
    .req_o          (req_o),
    .ack_i          (ack_i),
    .rdata_i        (rdata_i),
    .state_o        (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (txn %0d, t=%0t)", tag, got, exp, txn_no, $time);
    end
  endtask

  // One LPC clock: drive host nibble and responder, advance, sample at negedge.
  task automatic cycle(input logic lf, input logic [3:0] nib);
    logic acked;
    lpc_lframe_n_i = lf;
    lpc_lad_i      = nib;
    if (req_o) ack_i = (req_cnt > ack_delay);
    else       ack_i = ($urandom_range(0, 3) == 0); // stray acks must be ignored
    rdata_i = ack_i ? cur_rdata : 8'($urandom);
    acked   = req_o && ack_i;
    @(posedge clk);
    @(negedge clk);
    if (req_o) req_cnt++;
    else       req_cnt = 0;
    if (acked) check("req_drop", 32'(req_o), 32'd0);
  endtask

  task automatic send_header(input logic wr, input logic mem, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic do_start, input int ext);
    logic [3:0] cyc;
    cyc = {1'b0, mem, wr, 1'b0};
    if (do_start) repeat (ext + 1) cycle(1'b0, 4'h0);
    cycle(1'b1, cyc);
    check("oe_cyc", 32'(lpc_lad_oe_o), 32'd0);
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, addr[i*4 +: 4]);
      check("oe_addr", 32'(lpc_lad_oe_o), 32'd0);
    end
    if (wr) begin
      check("req_wd", 32'(req_o), 32'd0);
      cycle(1'b1, wdata[3:0]);
      cycle(1'b1, wdata[7:4]);
      check("oe_wdata", 32'(lpc_lad_oe_o), 32'd0);
    end
  endtask

  task automatic run_txn(input logic wr, input logic mem, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata,
                         input int d, input logic do_start);
    logic       hit;
    int         waits;
    logic [3:0] exp_q[$];
    txn_no++;
    ack_delay = d;
    cur_rdata = rdata;
    hit       = ((addr & MASK) == (BASE & MASK));
    waits     = (d > 0) ? d - 1 : 0;
    $display("txn %0d: %s %s addr=%h wdata=%h rdata=%h ack_delay=%0d hit=%0b",
             txn_no, mem ? "mem" : "io", wr ? "wr" : "rd", addr, wdata, rdata, d, hit);
    send_header(wr, mem, addr, wdata, do_start, $urandom_range(0, 2));
    if (!hit) begin
      check("req_miss", 32'(req_o), 32'd0);
      for (int i = 0; i < 6; i++) begin
        cycle(1'b1, 4'hF);
        check("oe_miss", 32'(lpc_lad_oe_o), 32'd0);
        check("req_miss", 32'(req_o), 32'd0);
      end
      return;
    end
    check("req_rise", 32'(req_o), 32'd1);
    check("addr", 32'(addr_o), 32'(addr));
    check("wr", 32'(wr_o), 32'(wr));
    check("mem", 32'(mem_o), 32'(mem));
    if (wr) check("wdata", 32'(wdata_o), 32'(wdata));
    check("oe_htar0", 32'(lpc_lad_oe_o), 32'd0);
    cycle(1'b1, 4'hF); // host drives 1111 in HTAR0
    check("oe_htar1", 32'(lpc_lad_oe_o), 32'd0);
    if (wr) check("wdata_hold", 32'(wdata_o), 32'(wdata));
    // Expected LAD response from the protocol rules.
    if (waits <= MAXW) begin
      repeat (waits) exp_q.push_back(4'b0110);
      exp_q.push_back(4'b0000);
      if (!wr) begin
        exp_q.push_back(rdata[3:0]);
        exp_q.push_back(rdata[7:4]);
      end
    end else begin
      repeat (MAXW) exp_q.push_back(4'b0110);
      exp_q.push_back(4'b1010);
    end
    exp_q.push_back(4'hF);
    cycle(1'b1, 4'hF); // host floats in HTAR1
    foreach (exp_q[i]) begin
      check("oe_resp", 32'(lpc_lad_oe_o), 32'd1);
      check("lad_resp", 32'(lpc_lad_o), 32'(exp_q[i]));
      cycle(1'b1, 4'hF);
    end
    check("oe_release", 32'(lpc_lad_oe_o), 32'd0);
    check("req_end", 32'(req_o), 32'd0);
    cycle(1'b1, 4'hF);
    check("oe_idle", 32'(lpc_lad_oe_o), 32'd0);
  endtask

  initial begin
    logic        r_wr, r_mem;
    logic [15:0] r_addr;
    logic [3:0]  top;
    rst_i          = 1'b1;
    lpc_lframe_n_i = 1'b1;
    lpc_lad_i      = 4'hF;
    ack_i          = 1'b0;
    rdata_i        = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oe", 32'(lpc_lad_oe_o), 32'd0);
    check("rst_lad", 32'(lpc_lad_o), 32'hF);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_wr", 32'(wr_o), 32'd0);
    check("rst_mem", 32'(mem_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_wdata", 32'(wdata_o), 32'd0);
    rst_i = 1'b0;
    cycle(1'b1, 4'hF);
    cycle(1'b1, 4'hF);

    // Directed protocol cases.
    run_txn(1'b0, 1'b0, 16'h1080, 8'h00, 8'hA5, 0, 1'b1);    // fastest read
    run_txn(1'b1, 1'b0, 16'h102E, 8'h3C, 8'h00, 3, 1'b1);    // two long waits
    run_txn(1'b0, 1'b1, 16'h2000, 8'h00, 8'h77, 0, 1'b1);    // decode miss
    run_txn(1'b0, 1'b0, 16'h1010, 8'h00, 8'h11, 1000, 1'b1); // no ack -> error SYNC

    // Host abort in the middle of SYNC, followed directly by a new cycle.
    txn_no++;
    $display("txn %0d: io rd addr=1234 aborted mid-SYNC", txn_no);
    ack_delay = 1000;
    send_header(1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 0);
    cycle(1'b1, 4'hF);
    cycle(1'b1, 4'hF);
    check("abort_sync", 32'(lpc_lad_o), 32'h6);
    cycle(1'b1, 4'hF);
    check("abort_oe_pre", 32'(lpc_lad_oe_o), 32'd1);
    cycle(1'b0, 4'h0);
    check("abort_oe", 32'(lpc_lad_oe_o), 32'd0);
    check("abort_req", 32'(req_o), 32'd0);
    run_txn(1'b1, 1'b1, 16'h1ABC, 8'h5A, 8'h00, 2, 1'b0);

    // Reset while read data is on LAD.
    txn_no++;
    $display("txn %0d: io rd addr=1080 reset during RDATA0", txn_no);
    ack_delay = 0;
    cur_rdata = 8'hC3;
    send_header(1'b0, 1'b0, 16'h1080, 8'h00, 1'b1, 0);
    cycle(1'b1, 4'hF);
    cycle(1'b1, 4'hF);
    check("rst_t_sync", 32'(lpc_lad_o), 32'h0);
    cycle(1'b1, 4'hF);
    check("rst_t_rdata0", 32'(lpc_lad_o), 32'h3);
    rst_i = 1'b1;
    cycle(1'b1, 4'hF);
    rst_i = 1'b0;
    check("rst_t_oe", 32'(lpc_lad_oe_o), 32'd0);
    check("rst_t_req", 32'(req_o), 32'd0);
    check("rst_t_lad", 32'(lpc_lad_o), 32'hF);
    check("rst_t_addr", 32'(addr_o), 32'd0);
    run_txn(1'b0, 1'b0, 16'h10F0, 8'h00, 8'h96, 1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r_wr  = 1'($urandom);
      r_mem = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        top = 4'h1;
      end else begin
        top = 4'($urandom_range(0, 14));
        if (top >= 4'h1) top = top + 4'h1;
      end
      r_addr = {top, 12'($urandom)};
      run_txn(r_wr, r_mem, r_addr, 8'($urandom), 8'($urandom),
              $urandom_range(0, MAXW + 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
